// File: rtl/nibble_cnt_pkg.sv
// Shared constants and nibble helpers for the nibble counter family.
package nibble_cnt_pkg;

    localparam int NIBBLE_W = 4;

    function automatic logic nib_is_zero(input logic [NIBBLE_W-1:0] i_nib);
        return i_nib == '0;
    endfunction

    function automatic logic nib_is_one(input logic [NIBBLE_W-1:0] i_nib);
        return i_nib == NIBBLE_W'(1);
    endfunction

endpackage

// File: rtl/nibble_down_stage.sv
// One 4-bit down-counting digit with its registered borrow-lookahead flag.
module nibble_down_stage
    import nibble_cnt_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] INIT_NIB = '0
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [NIBBLE_W-1:0] i_load_nib,
    input  logic                i_en,
    input  logic                i_borrow_in,
    input  logic                i_lowest,
    output logic [NIBBLE_W-1:0] o_nib,
    output logic                o_b
);

    logic [NIBBLE_W-1:0] r_nib;
    logic                r_b;

    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge flags of its neighbours, exactly like the hardware does.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_nib <= INIT_NIB;
            r_b   <= nib_is_zero(INIT_NIB);
        end else if (i_load) begin
            r_nib <= i_load_nib;
            r_b   <= nib_is_zero(i_load_nib);
        end else if (i_en) begin
            if (i_lowest || i_borrow_in)
                r_nib <= r_nib - NIBBLE_W'(1);
            // Lowest flag looks ahead one count; upper flags may lag one edge
            // after a 0->F wrap below them, which is harmless while b[0] is low.
            r_b <= i_lowest ? nib_is_one(r_nib) : nib_is_zero(r_nib);
        end
    end

    assign o_nib = r_nib;
    assign o_b   = r_b;

endmodule

// File: rtl/nibble_down_counter.sv
// Nibble-staged down-counter with load, zero flag and terminal-count pulse.
// Optional auto-reload at zero: define NIBBLE_DOWN_COUNTER_RELOAD_EN.
module nibble_down_counter
    import nibble_cnt_pkg::*;
#(
    parameter int                         DIGITS       = 4,
    parameter logic [NIBBLE_W*DIGITS-1:0] INIT_VALUE   = '0,
    parameter logic [NIBBLE_W*DIGITS-1:0] RELOAD_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [NIBBLE_W*DIGITS-1:0] i_load_value,
    input  logic                       i_en,
    output logic [NIBBLE_W*DIGITS-1:0] q,
    output logic                       o_zero,
    output logic                       o_tc
);

    localparam int W = NIBBLE_W * DIGITS;

    logic [DIGITS-1:0] w_b;
    logic [DIGITS-1:0] w_borrow;
    logic              w_load;
    logic [W-1:0]      w_load_value;
    logic              r_tc;

    assign o_zero = &w_b;

`ifdef NIBBLE_DOWN_COUNTER_RELOAD_EN
    logic w_reload;
    assign w_reload     = i_en & o_zero & ~i_load;
    assign w_load       = i_load | w_reload;
    assign w_load_value = i_load ? i_load_value : RELOAD_VALUE;
`else
    logic w_unused_reload;
    assign w_unused_reload = ^RELOAD_VALUE;
    assign w_load          = i_load;
    assign w_load_value    = i_load_value;
`endif

    assign w_borrow[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_stage
        if (k > 0) begin : g_chain
            assign w_borrow[k] = w_borrow[k-1] & w_b[k-1];
        end

        nibble_down_stage #(
            .INIT_NIB (INIT_VALUE[k*NIBBLE_W +: NIBBLE_W])
        ) u_stage (
            .clk         (clk),
            .i_rst       (i_rst),
            .i_load      (w_load),
            .i_load_nib  (w_load_value[k*NIBBLE_W +: NIBBLE_W]),
            .i_en        (i_en),
            .i_borrow_in (w_borrow[k]),
            .i_lowest    (1'(k == 0)),
            .o_nib       (q[k*NIBBLE_W +: NIBBLE_W]),
            .o_b         (w_b[k])
        );
    end

    // Pulses on the edge where q goes 1 -> 0; a load or reset to 0 never fires it.
    always_ff @(posedge clk) begin
        if (i_rst)
            r_tc <= 1'b0;
        else
            r_tc <= i_en & ~i_load & nib_is_one(q[NIBBLE_W-1:0]) & (&w_b[DIGITS-1:1]);
    end

    assign o_tc = r_tc;

endmodule

// File: tb/tb_nibble_down_counter.sv
// Scoreboard bench for nibble_down_counter (DIGITS=4) with a behavioural model.
module tb_nibble_down_counter;

    localparam logic [15:0] INIT   = 16'h0012;
    localparam logic [15:0] RELOAD = 16'h0003;

    typedef struct packed {
        logic [15:0] q;
        logic        zero;
        logic        tc;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_load = 1'b0;
    logic [15:0] i_load_value = '0;
    logic        i_en = 1'b0;
    logic [15:0] q;
    logic        o_zero;
    logic        o_tc;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_q   = 0;

    nibble_down_counter #(
        .DIGITS       (4),
        .INIT_VALUE   (INIT),
        .RELOAD_VALUE (RELOAD)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .i_en         (i_en),
        .q            (q),
        .o_zero       (o_zero),
        .o_tc         (o_tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, then push the model's prediction for the post-edge state.
    task automatic step(input logic rst, input logic load, input logic [15:0] val, input logic en);
        int unsigned old_q;
        exp_t        e;
        i_rst        = rst;
        i_load       = load;
        i_load_value = val;
        i_en         = en;
        @(posedge clk);
        #1;
        old_q = m_q;
        if (rst)
            m_q = INIT;
        else if (load)
            m_q = val;
        else if (en) begin
`ifdef NIBBLE_DOWN_COUNTER_RELOAD_EN
            m_q = (m_q == 0) ? RELOAD : m_q - 1;
`else
            m_q = (m_q + 32'hFFFF) % 32'h10000;
`endif
        end
        e.q    = m_q[15:0];
        e.zero = (m_q == 0);
        e.tc   = !rst && !load && en && (old_q == 1);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("q", 32'(q), 32'(e.q));
            check("o_zero", 32'(o_zero), 32'(e.zero));
            check("o_tc", 32'(o_tc), 32'(e.tc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        step(1, 0, 16'h0, 0);
        step(1, 1, 16'h5555, 1);

        // Count 0x0012 down to 0 and one cycle beyond (wrap or reload).
        for (int i = 0; i < 19; i++) step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 0);

        // Borrow across three zero nibbles right after a load.
        step(0, 1, 16'h1000, 0);
        step(0, 0, 16'h0, 1);

        // Enable at zero: wrap to FFFF, or reload 3 when the macro is set.
        step(0, 1, 16'h0000, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 1);

        // Simultaneous events.
        step(0, 1, 16'h00A5, 1);
        step(0, 0, 16'h0, 1);
        step(1, 1, 16'h7777, 1);
        step(0, 1, 16'h0001, 0);
        step(0, 1, 16'h0000, 1);
        step(0, 0, 16'h0, 0);

        // Random enable gaps from 0x0101 down to 0x00FE.
        step(0, 1, 16'h0101, 0);
        guard = 0;
        while (m_q != 32'h00FE && guard < 200) begin
            step(0, 0, 16'h0, 1'($urandom_range(0, 1)));
            guard++;
        end

        // Random gaps through zero and a wrap.
        step(0, 1, 16'h0002, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 16'h0, 1'($urandom_range(0, 1)));

        // Mixed random traffic with occasional loads near nibble boundaries.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2)
                step(1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            else if (r < 8)
                step(0, 1, 16'($urandom_range(0, 3)) << (4 * $urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            else
                step(0, 0, 16'h0, 1'($urandom_range(0, 9) < 7));
        end

        step(0, 0, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
